// File: rtl/rv32_exec_core.sv
// RV32I single-cycle execute core: PC register, decode, immediates, ALU and next-PC.
// Register file and data memory live outside; this block only supplies addresses and controls.
module rv32_exec_core #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] pc,
  output logic [31:0] dnpc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_wen,
  output logic [31:0] alu_result,
  output logic        mem_load,
  output logic        mem_store,
  output logic [3:0]  mem_wmask,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        illegal,
  output logic        ebreak
);

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {A_SRC1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {B_SRC2, B_IMM, B_FOUR} b_sel_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef enum logic [1:0] {NPC_SEQ, NPC_JAL, NPC_JALR, NPC_BR} npc_sel_e;

  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  a_sel_e      a_sel;
  b_sel_e      b_sel;
  imm_sel_e    imm_sel;
  npc_sel_e    npc_sel;
  logic [3:0]  alu_op;
  logic        wb_en, ld_en, st_en, ill, ebrk;

  logic [31:0] imm, op_a, op_b, alu_out;
  logic [4:0]  shamt;
  logic        br_taken;
  logic [31:0] pc_plus4, pc_plus_imm, jalr_tgt;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    a_sel   = A_SRC1;
    b_sel   = B_IMM;
    imm_sel = IMM_I;
    npc_sel = NPC_SEQ;
    alu_op  = 4'b0000;
    wb_en   = 1'b0;
    ld_en   = 1'b0;
    st_en   = 1'b0;
    ill     = 1'b0;
    ebrk    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        a_sel   = A_ZERO;
        imm_sel = IMM_U;
        wb_en   = 1'b1;
      end
      OPC_AUIPC: begin
        a_sel   = A_PC;
        imm_sel = IMM_U;
        wb_en   = 1'b1;
      end
      OPC_JAL: begin
        a_sel   = A_PC;
        b_sel   = B_FOUR;
        imm_sel = IMM_J;
        npc_sel = NPC_JAL;
        wb_en   = 1'b1;
      end
      OPC_JALR: begin
        a_sel   = A_PC;
        b_sel   = B_FOUR;
        npc_sel = NPC_JALR;
        wb_en   = 1'b1;
        ill     = (funct3 != 3'b000);
      end
      OPC_OPIMM: begin
        // Only SRAI borrows funct7[5]; ADDI with inst[30] set stays an add.
        alu_op = {(funct3 == 3'b101) && inst[30], funct3};
        wb_en  = 1'b1;
        ill    = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                 ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OPC_OP: begin
        b_sel  = B_SRC2;
        alu_op = {inst[30], funct3};
        wb_en  = 1'b1;
        ill    = !((funct7 == 7'h00) ||
                   ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_LOAD: begin
        wb_en = 1'b1;
        ld_en = 1'b1;
        ill   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
        st_en   = 1'b1;
        ill     = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        b_sel   = B_SRC2;
        imm_sel = IMM_B;
        npc_sel = NPC_BR;
        alu_op  = 4'b1000;
        ill     = (funct3[2:1] == 2'b01);
      end
      OPC_SYSTEM: begin
        if (inst == INST_EBREAK) ebrk = 1'b1;
        else                     ill  = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    case (imm_sel)
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

  always_comb begin
    case (a_sel)
      A_SRC1:  op_a = src1;
      A_PC:    op_a = pc_q;
      default: op_a = 32'd0;
    endcase
    case (b_sel)
      B_SRC2:  op_b = src2;
      B_IMM:   op_b = imm;
      default: op_b = 32'd4;
    endcase
  end

  assign shamt = op_b[4:0];

  always_comb begin
    case (alu_op)
      4'b1000: alu_out = op_a - op_b;
      4'b0001: alu_out = op_a << shamt;
      4'b0010: alu_out = {31'b0, $signed(op_a) < $signed(op_b)};
      4'b0011: alu_out = {31'b0, op_a < op_b};
      4'b0100: alu_out = op_a ^ op_b;
      4'b0101: alu_out = op_a >> shamt;
      4'b1101: alu_out = $signed(op_a) >>> shamt;
      4'b0110: alu_out = op_a | op_b;
      4'b0111: alu_out = op_a & op_b;
      default: alu_out = op_a + op_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (src1 == src2);
      3'b001:  br_taken = (src1 != src2);
      3'b100:  br_taken = ($signed(src1) < $signed(src2));
      3'b101:  br_taken = !($signed(src1) < $signed(src2));
      3'b110:  br_taken = (src1 < src2);
      3'b111:  br_taken = !(src1 < src2);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4    = pc_q + 32'd4;
  assign pc_plus_imm = pc_q + imm;
  // Only bit 0 is cleared; a misaligned bit 1 passes through untrapped.
  assign jalr_tgt    = (src1 + imm) & ~32'd1;

  always_comb begin
    dnpc = pc_plus4;
    if (!ill) begin
      case (npc_sel)
        NPC_JAL:  dnpc = pc_plus_imm;
        NPC_JALR: dnpc = jalr_tgt;
        NPC_BR:   dnpc = br_taken ? pc_plus_imm : pc_plus4;
        default:  dnpc = pc_plus4;
      endcase
    end
  end

  assign pc_d = dnpc;

  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign pc           = pc_q;
  assign rs1          = inst[19:15];
  assign rs2          = inst[24:20];
  assign rd           = inst[11:7];
  assign alu_result   = alu_out;
  assign reg_wen      = wb_en && !ill && rst && (rd != 5'd0);
  assign mem_load     = ld_en && !ill && rst;
  assign mem_store    = st_en && !ill && rst;
  assign mem_size     = funct3[1:0];
  assign mem_unsigned = funct3[2];
  assign illegal      = ill;
  assign ebreak       = ebrk;

  always_comb begin
    mem_wmask = 4'b0000;
    if (mem_store) begin
      case (funct3[1:0])
        2'b00:   mem_wmask = 4'b0001;
        2'b01:   mem_wmask = 4'b0011;
        default: mem_wmask = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_exec_core.sv
// Bench for rv32_exec_core: directed vector table, short PC sequences,
// then random legal/illegal instructions checked against an ISA-level model.
module tb_rv32_exec_core;

  localparam logic [31:0] P = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, src1, src2;
  logic [31:0] pc, dnpc, alu_result;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_wen, mem_load, mem_store, mem_unsigned, illegal, ebreak;
  logic [3:0]  mem_wmask;
  logic [1:0]  mem_size;

  int checks = 0;
  int errors = 0;

  rv32_exec_core #(.RESET_PC(P)) dut (
    .clk(clk), .rst(rst), .inst(inst), .src1(src1), .src2(src2),
    .pc(pc), .dnpc(dnpc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_wen(reg_wen), .alu_result(alu_result),
    .mem_load(mem_load), .mem_store(mem_store), .mem_wmask(mem_wmask),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .illegal(illegal), .ebreak(ebreak)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [31:0] i, s1, s2;
    logic        chk_alu;
    logic [31:0] alu, dnpc;
    logic        wen, ld, st;
    logic [3:0]  wmask;
    logic [1:0]  size;
    logic        uns, ill, ebk;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] res;
    sh = b[4:0];
    case (f3)
      3'd0: res = alt ? a - b : a + b;
      3'd1: res = a << sh;
      3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: res = (a < b) ? 32'd1 : 32'd0;
      3'd4: res = a ^ b;
      3'd5: begin
        if (alt) res = $signed(a) >>> sh;
        else     res = a >> sh;
      end
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    return res;
  endfunction

  function automatic vec_t model(input logic r, input logic [31:0] i, input logic [31:0] s1,
                                 input logic [31:0] s2, input logic [31:0] p);
    vec_t e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        wb, ld, st, tk;
    f3 = i[14:12];
    f7 = i[31:25];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    e.r = r; e.i = i; e.s1 = s1; e.s2 = s2;
    e.chk_alu = 1'b1; e.alu = 32'd0; e.dnpc = p + 32'd4;
    e.wmask = 4'b0000; e.size = f3[1:0]; e.uns = f3[2];
    e.ill = 1'b0; e.ebk = 1'b0;
    wb = 1'b0; ld = 1'b0; st = 1'b0; tk = 1'b0;
    case (i[6:0])
      7'h37: begin e.alu = imm_u; wb = 1'b1; end
      7'h17: begin e.alu = p + imm_u; wb = 1'b1; end
      7'h6F: begin e.alu = p + 32'd4; e.dnpc = p + imm_j; wb = 1'b1; end
      7'h67: begin
        if (f3 != 3'd0) e.ill = 1'b1;
        else begin e.alu = p + 32'd4; e.dnpc = (s1 + imm_i) & 32'hFFFF_FFFE; wb = 1'b1; end
      end
      7'h13: begin
        if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) e.ill = 1'b1;
        else begin e.alu = alu_ref(f3, (f3 == 3'd5) && (f7 == 7'h20), s1, imm_i); wb = 1'b1; end
      end
      7'h33: begin
        if (f7 == 7'h00) begin e.alu = alu_ref(f3, 1'b0, s1, s2); wb = 1'b1; end
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          e.alu = alu_ref(f3, 1'b1, s1, s2); wb = 1'b1;
        end
        else e.ill = 1'b1;
      end
      7'h03: begin
        if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) begin
          e.alu = s1 + imm_i; ld = 1'b1; wb = 1'b1;
        end
        else e.ill = 1'b1;
      end
      7'h23: begin
        if (f3 <= 3'd2) begin
          e.alu = s1 + imm_s; st = 1'b1;
          e.wmask = (f3 == 3'd0) ? 4'b0001 : (f3 == 3'd1) ? 4'b0011 : 4'b1111;
        end
        else e.ill = 1'b1;
      end
      7'h63: begin
        e.chk_alu = 1'b0;
        case (f3)
          3'd0: tk = (s1 == s2);
          3'd1: tk = (s1 != s2);
          3'd4: tk = ($signed(s1) < $signed(s2));
          3'd5: tk = ($signed(s1) >= $signed(s2));
          3'd6: tk = (s1 < s2);
          3'd7: tk = (s1 >= s2);
          default: e.ill = 1'b1;
        endcase
        if (tk) e.dnpc = p + imm_b;
      end
      7'h73: begin
        e.chk_alu = 1'b0;
        if (i == 32'h0010_0073) e.ebk = 1'b1;
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.chk_alu = 1'b0; wb = 1'b0; ld = 1'b0; st = 1'b0; e.dnpc = p + 32'd4;
    end
    e.wen = wb && r && (i[11:7] != 5'd0);
    e.ld  = ld && r;
    e.st  = st && r;
    if (!e.st) e.wmask = 4'b0000;
    return e;
  endfunction

  task automatic check_outputs(input vec_t e, input string tag);
    chk({tag, ".dnpc"}, dnpc, e.dnpc);
    chk({tag, ".reg_wen"}, 32'(reg_wen), 32'(e.wen));
    chk({tag, ".mem_load"}, 32'(mem_load), 32'(e.ld));
    chk({tag, ".mem_store"}, 32'(mem_store), 32'(e.st));
    chk({tag, ".mem_wmask"}, 32'(mem_wmask), 32'(e.wmask));
    chk({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
    chk({tag, ".ebreak"}, 32'(ebreak), 32'(e.ebk));
    chk({tag, ".rs1"}, 32'(rs1), 32'(e.i[19:15]));
    chk({tag, ".rs2"}, 32'(rs2), 32'(e.i[24:20]));
    chk({tag, ".rd"}, 32'(rd), 32'(e.i[11:7]));
    if (e.chk_alu) chk({tag, ".alu_result"}, alu_result, e.alu);
    if (e.ld || e.st) begin
      chk({tag, ".mem_size"}, 32'(mem_size), 32'(e.size));
      chk({tag, ".mem_unsigned"}, 32'(mem_unsigned), 32'(e.uns));
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r, res;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          k;
    k  = int'($urandom_range(0, 10));
    r  = $urandom;
    f3 = r[14:12];
    case (k)
      0: res = {r[31:12], r[11:7], 7'h37};
      1: res = {r[31:12], r[11:7], 7'h17};
      2: res = {r[31:12], r[11:7], 7'h6F};
      3: res = {r[31:15], 3'b000, r[11:7], 7'h67};
      4: begin
        if (f3 == 3'd1) f7 = 7'h00;
        else if (f3 == 3'd5) f7 = r[30] ? 7'h20 : 7'h00;
        else f7 = r[31:25];
        res = {f7, r[24:15], f3, r[11:7], 7'h13};
      end
      5: begin
        f7  = (r[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
        res = {f7, r[24:15], f3, r[11:7], 7'h33};
      end
      6: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f3 = 3'd2;
        res = {r[31:15], f3, r[11:7], 7'h03};
      end
      7: begin
        if (f3 > 3'd2) f3 = {2'b00, r[12]};
        res = {r[31:15], f3, r[11:7], 7'h23};
      end
      8: begin
        if (f3 == 3'd2 || f3 == 3'd3) f3 = {1'b1, r[13:12]};
        res = {r[31:15], f3, r[11:7], 7'h63};
      end
      9: res = 32'h0010_0073;
      default: begin
        case (r[1:0])
          2'd0: res = {r[31:7], 7'h7F};
          2'd1: res = {r[31:7], 7'h0B};
          2'd2: res = {r[31:15], 2'b01, r[12], r[11:7], 7'h63};
          default: res = {r[31:15], 3'b011, r[11:7], 7'h03};
        endcase
      end
    endcase
    return res;
  endfunction

  vec_t        vq[$];
  vec_t        e;
  logic [31:0] exp_pc;

  initial begin
    // r, inst, src1, src2, chk_alu, alu, dnpc, wen, ld, st, wmask, size, uns, ill, ebk
    vq.push_back('{1'b1, 32'h00500093, 32'd0, 32'd0, 1'b1, 32'd5, P + 32'd4, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h40208233, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, P + 32'd4, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h123452B7, 32'd0, 32'd0, 1'b1, 32'h12345000, P + 32'd4, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 32'h40208233, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 32'h123452B7, 32'd0, 32'd0, 1'b1, 32'h12345000, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h40415093, P, 32'd0, 1'b1, 32'hF8000000, P + 32'd4, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h00415093, P, 32'd0, 1'b1, 32'h08000000, P + 32'd4, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h00208463, 32'd7, 32'd7, 1'b0, 32'd0, P + 32'd8, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h00208463, 32'd7, 32'd8, 1'b0, 32'd0, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h0020C463, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, P + 32'd8, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h0020E463, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h00209463, 32'd7, 32'd8, 1'b0, 32'd0, P + 32'd8, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h0020D463, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h0020F463, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, P + 32'd8, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h0020A463, 32'd1, 32'd1, 1'b0, 32'd0, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 32'h003100E7, 32'h80000100, 32'd0, 1'b1, P + 32'd4, 32'h80000102, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h010000EF, 32'd0, 32'd0, 1'b1, P + 32'd4, P + 32'd16, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h0020A423, 32'h80001000, 32'd0, 1'b1, 32'h80001008, P + 32'd4, 1'b0, 1'b0, 1'b1, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h00208023, 32'h100, 32'd0, 1'b1, 32'h100, P + 32'd4, 1'b0, 1'b0, 1'b1, 4'h1, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 32'h0020A423, 32'h80001000, 32'd0, 1'b1, 32'h80001008, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h0040A183, 32'h1000, 32'd0, 1'b1, 32'h1004, P + 32'd4, 1'b1, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 32'h0000007F, 32'd0, 32'd0, 1'b0, 32'd0, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 32'h00100073, 32'd0, 32'd0, 1'b0, 32'd0, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1});
    vq.push_back('{1'b1, 32'h00000073, 32'd0, 32'd0, 1'b0, 32'd0, P + 32'd4, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0});

    rst = 1'b0; inst = 32'h0000_0013; src1 = 32'd0; src2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, P);

    // Reset release, ADDI, then a JAL that must redirect the PC register.
    rst = 1'b1; inst = 32'h00500093; src1 = 32'd0;
    @(negedge clk);
    chk("seq_addi.alu", alu_result, 32'd5);
    chk("seq_addi.rd", 32'(rd), 32'd1);
    chk("seq_addi.wen", 32'(reg_wen), 32'd1);
    chk("seq_addi.dnpc", dnpc, P + 32'd4);
    @(posedge clk); #1;
    chk("seq_addi.pc", pc, P + 32'd4);
    inst = 32'h010000EF;
    @(negedge clk);
    chk("seq_jal.dnpc", dnpc, P + 32'd20);
    chk("seq_jal.alu", alu_result, P + 32'd8);
    @(posedge clk); #1;
    chk("seq_jal.pc", pc, P + 32'd20);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("seq_rst.pc", pc, P);

    foreach (vq[n]) begin
      rst = 1'b0;
      @(posedge clk); #1;
      rst = vq[n].r; inst = vq[n].i; src1 = vq[n].s1; src2 = vq[n].s2;
      @(negedge clk);
      check_outputs(vq[n], $sformatf("vec%0d", n));
    end

    rst = 1'b0;
    @(posedge clk); #1;
    exp_pc = P;
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 15) != 0);
      inst = gen_inst();
      src1 = $urandom;
      src2 = ($urandom_range(0, 3) == 0) ? src1 : $urandom;
      @(negedge clk);
      chk($sformatf("rnd%0d.pc", n), pc, exp_pc);
      e = model(rst, inst, src1, src2, exp_pc);
      check_outputs(e, $sformatf("rnd%0d", n));
      exp_pc = rst ? e.dnpc : P;
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
